// File: rtl/data_mem_unit.sv
// Memory stage: load/store requests into a word-organised data memory with byte lanes,
// configurable read latency and an in-order, backpressured response buffer.
module data_mem_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              isLd,
    input  logic              isSt,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [ADDR_W-1:0] aluResult,
    input  logic [DATA_W-1:0] op2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] DataMemResult,
    output logic              resp_err
);
    localparam int NBUF   = RD_LAT + 1;
    localparam int CNT_W  = $clog2(NBUF + 1);
    localparam int PTR_W  = $clog2(NBUF);
    localparam int MEM_AW = $clog2(DEPTH);
    localparam int WIDX_W = ADDR_W - 2;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [1:0] ln,
                                                      input logic [1:0] sz,
                                                      input logic uns);
        logic [DATA_W-1:0] sh;
        sh = word >> {ln, 3'b000};
        case (sz)
            SZ_B:    load_extend = uns ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                                       : {{(DATA_W-8){sh[7]}}, sh[7:0]};
            SZ_H:    load_extend = uns ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                                       : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NBUF - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [WIDX_W-1:0] widx;
    logic [MEM_AW-1:0] midx;
    logic [1:0]        lane;
    logic              accept, mem_op, fault, do_store, do_load;
    logic [3:0]        wr_be;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  out_cnt;

    assign widx      = aluResult[ADDR_W-1:2];
    assign midx      = widx[MEM_AW-1:0];
    assign lane      = aluResult[1:0];
    assign req_ready = !reset && (out_cnt < CNT_W'(NBUF));
    assign accept    = req_valid && req_ready;
    assign mem_op    = isLd || isSt;
    assign do_store  = accept && isSt && !fault;
    assign do_load   = isLd && !fault;

    // Nops carry don't-care size/address fields, so only real accesses can fault.
    always_comb begin
        fault = 1'b0;
        if (mem_op) begin
            case (size)
                SZ_B:    fault = 1'b0;
                SZ_H:    fault = lane[0];
                SZ_W:    fault = (lane != 2'b00);
                default: fault = 1'b1;
            endcase
            if ((isLd && isSt) || (widx >= WIDX_W'(DEPTH))) fault = 1'b1;
        end
    end

    always_comb begin
        case (size)
            SZ_B: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{op2[7:0]}};
            end
            SZ_H: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{op2[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = op2;
            end
        endcase
    end

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[midx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Stage p0: memory read and request attributes captured at the accepting edge
    logic              vld_p0, ld_p0, err_p0, uns_p0;
    logic [1:0]        lane_p0, size_p0;
    logic [DATA_W-1:0] word_p0, fmt_p0;

    always_ff @(posedge clk) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            word_p0 <= mem[midx];
            ld_p0   <= do_load;
            err_p0  <= fault;
            uns_p0  <= ld_unsigned;
            lane_p0 <= lane;
            size_p0 <= size;
        end
    end

    assign fmt_p0 = ld_p0 ? load_extend(word_p0, lane_p0, size_p0, uns_p0) : '0;

    // Stages p1..p(RD_LAT-1): fixed delay so every response matures after RD_LAT cycles
    logic              vld_last, err_last;
    logic [DATA_W-1:0] data_last;

    generate
        if (RD_LAT == 1) begin : g_no_dly
            assign vld_last  = vld_p0;
            assign data_last = fmt_p0;
            assign err_last  = err_p0;
        end else begin : g_dly
            logic              vld_pn  [RD_LAT-1];
            logic [DATA_W-1:0] data_pn [RD_LAT-1];
            logic              err_pn  [RD_LAT-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < RD_LAT - 1; i++) vld_pn[i] <= 1'b0;
                end else begin
                    vld_pn[0] <= vld_p0;
                    for (int i = 1; i < RD_LAT - 1; i++) vld_pn[i] <= vld_pn[i-1];
                end
            end

            always_ff @(posedge clk) begin
                data_pn[0] <= fmt_p0;
                err_pn[0]  <= err_p0;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    data_pn[i] <= data_pn[i-1];
                    err_pn[i]  <= err_pn[i-1];
                end
            end

            assign vld_last  = vld_pn[RD_LAT-2];
            assign data_last = data_pn[RD_LAT-2];
            assign err_last  = err_pn[RD_LAT-2];
        end
    endgenerate

    // Response buffer; an empty buffer is bypassed so a matured entry is visible at once.
    logic [DATA_W-1:0] buf_data [NBUF];
    logic              buf_err  [NBUF];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  buf_cnt;
    logic              buf_empty, pop, push, buf_pop;
    logic [DATA_W-1:0] head_data;
    logic              head_err;

    assign buf_empty  = (buf_cnt == '0);
    assign resp_valid = vld_last || !buf_empty;
    assign head_data  = buf_empty ? data_last : buf_data[rd_ptr];
    assign head_err   = buf_empty ? err_last  : buf_err[rd_ptr];
    assign pop        = resp_valid && resp_ready;
    assign buf_pop    = pop && !buf_empty;
    assign push       = vld_last && !(buf_empty && resp_ready);

    assign DataMemResult = resp_valid ? head_data : '0;
    assign resp_err      = resp_valid && head_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            buf_cnt <= '0;
            out_cnt <= '0;
        end else begin
            if (push)    wr_ptr <= ptr_inc(wr_ptr);
            if (buf_pop) rd_ptr <= ptr_inc(rd_ptr);
            buf_cnt <= buf_cnt + CNT_W'(push) - CNT_W'(buf_pop);
            out_cnt <= out_cnt + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= data_last;
            buf_err[wr_ptr]  <= err_last;
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: three instances (RD_LAT 1, 3, 4) driven one at a time;
// expectations are queued at acceptance and checked by a decoupled monitor.
module tb_data_mem_unit;
    localparam int NDUT = 3;
    localparam int DEPTH = 8192;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        isLd = 1'b0;
    logic        isSt = 1'b0;
    logic        ld_unsigned = 1'b0;
    logic        resp_ready = 1'b1;
    logic [1:0]  size = 2'b00;
    logic [31:0] aluResult = '0;
    logic [31:0] op2 = '0;

    logic        rq_ready [NDUT];
    logic        rs_valid [NDUT];
    logic [31:0] rs_data  [NDUT];
    logic        rs_err   [NDUT];

    int sel = 1;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int stalls = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        bit          chk_lat;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_mem_unit #(
            .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32),
            .RD_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid && (sel == g)), .req_ready(rq_ready[g]),
            .isLd(isLd), .isSt(isSt), .size(size), .ld_unsigned(ld_unsigned),
            .aluResult(aluResult), .op2(op2),
            .resp_valid(rs_valid[g]), .resp_ready(resp_ready),
            .DataMemResult(rs_data[g]), .resp_err(rs_err[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (dut %0d, cycle %0d): got %h, expected %h", name, sel, cyc, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rs_valid[sel]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp_valid", 32'(rs_valid[sel]), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("resp_data", rs_data[sel], e.data);
                    check("resp_err", 32'(rs_err[sel]), 32'(e.err));
                    if (resp_ready) begin
                        if (e.chk_lat) check("resp_latency", cyc - e.acc, lat_of(sel));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        int waited;
        isLd = ld; isSt = st; size = sz; ld_unsigned = uns;
        aluResult = addr; op2 = wd; req_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!rq_ready[sel] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited != 0) stalls++;
        if (!rq_ready[sel]) begin
            check("accept_timeout", 32'(rq_ready[sel]), 32'd1);
        end else begin
            e.data = exp_d; e.err = exp_e; e.acc = cyc; e.chk_lat = resp_ready;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] d);
        issue(1'b0, 1'b1, sz, 1'b0, addr, d, 32'h0, 1'b0);
    endtask

    task automatic do_ld(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [31:0] exp_d);
        issue(1'b1, 1'b0, sz, uns, addr, 32'h0, exp_d, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        logic [31:0] d;
        fork
            monitor();
        join_none

        // Reset values on every instance
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check("rst_req_ready", 32'(rq_ready[g]), 32'd0);
            check("rst_resp_valid", 32'(rs_valid[g]), 32'd0);
            check("rst_data", rs_data[g], 32'd0);
            check("rst_err", 32'(rs_err[g]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) check("ready_after_reset", 32'(rq_ready[g]), 32'd1);
        @(posedge clk); #1;

        // Word round trip, lane merge, extension (RD_LAT=3)
        sel = 1;
        do_st(SZ_W, 32'h100, 32'h12345678);
        do_ld(SZ_W, 1'b0, 32'h100, 32'h12345678);
        do_st(SZ_B, 32'h101, 32'hABCDEF80);
        do_ld(SZ_B, 1'b0, 32'h101, 32'hFFFFFF80);
        do_ld(SZ_B, 1'b1, 32'h101, 32'h00000080);
        do_ld(SZ_W, 1'b0, 32'h100, 32'h12348078);
        do_ld(SZ_H, 1'b0, 32'h102, 32'h00001234);
        do_ld(SZ_H, 1'b1, 32'h100, 32'h00008078);
        do_ld(SZ_H, 1'b0, 32'h100, 32'hFFFF8078);
        do_ld(SZ_B, 1'b0, 32'h103, 32'h00000012);
        do_st(SZ_W, 32'h104, 32'h00000000);
        do_st(SZ_H, 32'h106, 32'h1234BEEF);
        do_ld(SZ_W, 1'b0, 32'h104, 32'hBEEF0000);
        do_ld(SZ_H, 1'b0, 32'h106, 32'hFFFFBEEF);
        do_st(SZ_W, 32'h0, 32'h00000000);

        // Faults and nops
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, SZ_H, 1'b0, 32'h103, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, SZ_X, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 1'b1, SZ_W, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b1, 1'b0, SZ_W, 1'b0, DEPTH * 4, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 1'b1, SZ_W, 1'b0, DEPTH * 4, 32'hCAFEF00D, 32'h0, 1'b1);
        issue(1'b0, 1'b1, SZ_H, 1'b0, 32'h101, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b0);
        issue(1'b0, 1'b0, SZ_X, 1'b0, 32'h103, 32'h0, 32'h0, 1'b0);
        do_ld(SZ_W, 1'b0, 32'h100, 32'h12348078);
        do_ld(SZ_W, 1'b0, 32'h0, 32'h00000000);
        drain();

        // Backpressure at RD_LAT=3: six loads offered, four accepted
        for (int k = 0; k < 6; k++) do_st(SZ_W, 32'h200 + 4 * k, 32'hA0000000 + k);
        drain();
        resp_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            isLd = 1'b1; isSt = 1'b0; size = SZ_W; ld_unsigned = 1'b0; op2 = '0;
            aluResult = 32'h200 + 4 * n;
            req_valid = (n < 6);
            @(negedge clk);
            if (req_valid && rq_ready[sel]) begin
                e.data = 32'hA0000000 + n; e.err = 1'b0; e.acc = cyc; e.chk_lat = 1'b0;
                exp_q.push_back(e);
                n++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("bp_accepted", n, 32'd4);
        @(negedge clk);
        check("bp_ready_low", 32'(rq_ready[sel]), 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", 32'(rq_ready[sel]), 32'd0);
        @(negedge clk);
        check("bp_ready_after_pop", 32'(rq_ready[sel]), 32'd1);
        @(posedge clk); #1;
        drain();

        // Streaming at RD_LAT=1 and RD_LAT=4
        for (int s = 0; s < 2; s++) begin
            sel = (s == 0) ? 0 : 2;
            stalls = 0;
            for (int k = 0; k < 32; k++) begin
                d = 32'hDEADBEEF ^ (32'h01010101 * k);
                do_st(SZ_W, 32'h1000 + 4 * k, d);
                do_ld(SZ_W, 1'b0, 32'h1000 + 4 * k, d);
            end
            drain();
            check("stream_no_stall", stalls, 32'd0);
        end

        // Reset mid-stream with three loads outstanding (RD_LAT=3)
        sel = 1;
        resp_ready = 1'b0;
        do_ld(SZ_W, 1'b0, 32'h200, 32'hA0000000);
        do_ld(SZ_W, 1'b0, 32'h204, 32'hA0000001);
        do_ld(SZ_W, 1'b0, 32'h208, 32'hA0000002);
        reset = 1'b1;
        exp_q.delete();
        isLd = 1'b0; isSt = 1'b1; size = SZ_W; aluResult = 32'h100; op2 = 32'hFFFFFFFF;
        req_valid = 1'b1;
        @(negedge clk);
        check("ready_in_reset", 32'(rq_ready[sel]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("valid_after_reset", 32'(rs_valid[sel]), 32'd0);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        do_ld(SZ_W, 1'b0, 32'h100, 32'h12348078);
        do_ld(SZ_W, 1'b0, 32'h204, 32'hA0000001);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised memory-stage block: accepts load/store requests from the execute stage with a valid/ready handshake and accesses an internal word-organised data memory. Supports byte, halfword and word access with byte-lane write enables, and sign or zero extension on loads. Read latency is configurable. Responses return in order through a bounded response buffer with backpressure. Sits between the ALU and writeback, replacing the fixed 32-bit, always-ready memory stage and data memory pair.

## Interface
- DATA_W, 32, data width; fixed at 32 in this generation; lane logic assumes 4 bytes.
- DEPTH, 8192, number of DATA_W words in the memory.
- ADDR_W, 32, byte-address width.
- RD_LAT, 1, cycles from request acceptance to first possible response; legal range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- isLd  in  1  load request.
- isSt  in  1  store request.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- ld_unsigned  in  1  zero-extend load data (1) or sign-extend (0).
- aluResult  in  ADDR_W  byte address.
- op2  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- DataMemResult  out  DATA_W  load data; 0 for stores, nops and errors.
- resp_err  out  1  response is for a faulted request.

## Operation
- Accept: req_valid && req_ready. Every accepted request produces exactly one response, in acceptance order.
- Word index: aluResult[ADDR_W-1:2]. Lane: aluResult[1:0]. Little-endian, so byte 0 is bits [7:0].
- Fault conditions, checked at accept:
  - isLd && isSt
  - size==11
  - halfword access with addr[0]=1
  - word access with addr[1:0]!=0
  - word index >= DEPTH, checked for loads and stores
- A faulted request performs no memory access and responds with resp_err=1 and DataMemResult=0.
- Nop: accepted with isLd=0 and isSt=0. Responds with data 0 and err 0. Keeps response ordering intact.
- Store: written at the accepting clock edge.
  - Byte: write op2[7:0] to lane addr[1:0].
  - Halfword: write op2[15:0] to lanes addr[1]*2 and addr[1]*2+1.
  - Word: write all 4 lanes.
  - Unselected lanes are unchanged.
- Load: the word is read after any write at the same edge. Because only one request is accepted per cycle, a load accepted the cycle after a store sees the store's data. The selected lane(s) are shifted to bit 0, then zero- or sign-extended per ld_unsigned. ld_unsigned is ignored for word loads.
- Response path: a RD_LAT-stage pipeline feeds an in-order response buffer of RD_LAT+1 entries.
- Outstanding count: requests accepted but not yet consumed; range 0..RD_LAT+1.
  - Increments on accept, decrements on resp_valid && resp_ready.
  - Unchanged when both happen in the same cycle.
- req_ready = !reset && (count < RD_LAT+1). It is a function of registered state only, with no combinational path from resp_ready.
- resp_valid is high whenever the buffer head holds a matured entry. DataMemResult and resp_err hold steady while resp_valid && !resp_ready.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values:
  - req_ready=0 while reset is high, 1 on the first cycle after reset.
  - resp_valid=0, DataMemResult=0, resp_err=0.
  - Outstanding count 0; pipeline and buffer empty.
- Reset mid-operation drops all in-flight and buffered responses. Stores already written stay written. A request presented during reset is not accepted.
- Latency: a request accepted at edge N gives resp_valid high in the cycle after edge N+RD_LAT-1. This means RD_LAT cycles after acceptance when resp_ready has been held at 1.
- Throughput: one request per cycle indefinitely while resp_ready=1.
- Backpressure: with resp_ready=0, at most RD_LAT+1 requests are accepted, then req_ready drops. It rises again in the cycle after the first response is consumed.
- Response delivery is in acceptance order regardless of type; faults and nops take the same latency as loads.

## Test plan
- Word round trip: sw 0x12345678 @0x100, then lw @0x100 → DataMemResult=0x12345678, resp_err=0, response RD_LAT cycles after accept.
- Lane merge and extension: after the above, sb 0x80 @0x101.
  - lb @0x101 → 0xFFFFFF80
  - lbu @0x101 → 0x00000080
  - lw @0x100 → 0x12348078
  - lh @0x102 → 0x00001234
- Faults: lw @0x102, lh @0x103, size=11, isLd&isSt, lw @(DEPTH*4) → each gives resp_err=1 and data 0. A following lw @0x100 is unchanged at 0x12348078.
- Backpressure at RD_LAT=3:
  - Hold resp_ready=0 and issue 6 loads → exactly 4 accepted, then req_ready=0.
  - Release resp_ready → responses come out in order with stable data while stalled, and req_ready returns one cycle after the first consumption.
- Streaming at RD_LAT=1 and RD_LAT=4: 32 back-to-back sw/lw pairs to distinct addresses with resp_ready=1 → req_ready never drops, and every load returns the preceding store's data.
- Reset mid-stream: 3 loads outstanding, pulse reset for 1 cycle → resp_valid=0 with no stale responses. Memory written before reset still reads back correctly.
